// File: rtl/t03_pad_poller.sv
// Parametrised serial game-pad poller: drives the shared latch/pulse strobes, shifts every
// pad in parallel and presents active-high button words with a one-clk valid strobe.
module t03_pad_poller #(
   parameter int NUM_PADS    = 2,
   parameter int BITS        = 8,
   parameter int DIV         = 40,
   parameter int LATCH_TICKS = 12,
   parameter int HALF_TICKS  = 6,
   parameter int POLL_TICKS  = 16667
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en_i,
   input  logic                     trig_i,
   input  logic [NUM_PADS-1:0]      pad_data_i,
   output logic                     pad_latch_o,
   output logic                     pad_pulse_o,
   output logic [NUM_PADS*BITS-1:0] buttons_o,
   output logic [NUM_PADS-1:0]      present_o,
   output logic                     valid_o,
   output logic                     busy_o
);

   localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TMAX = (LATCH_TICKS > HALF_TICKS) ? LATCH_TICKS : HALF_TICKS;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int BW   = $clog2(BITS + 1);
   localparam int PW   = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LATCH = 3'd1,
      S_PHI   = 3'd2,
      S_PLO   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                     state_q, state_d;
   logic [DW-1:0]              div_q, div_d;
   logic [PW-1:0]              ptmr_q, ptmr_d;
   logic [TW-1:0]              tcnt_q, tcnt_d;
   logic [BW-1:0]              bitcnt_q, bitcnt_d;
   logic                       trig_pend_q, trig_pend_d;
   logic [NUM_PADS-1:0]        sync1_q, sync2_q;
   logic [NUM_PADS*BITS-1:0]   raw_q, raw_d;
   logic                       latch_q, pulse_q, busy_q, valid_q;
   logic [NUM_PADS*BITS-1:0]   buttons_q, buttons_d;
   logic [NUM_PADS-1:0]        present_q, present_d;
   logic                       tick_s, start_s, sample_s;

   // Tick divider and poll-period timer next state
   always_comb begin
      tick_s = (div_q == DW'(DIV - 1));
      div_d  = tick_s ? '0 : div_q + DW'(1);
      ptmr_d = ptmr_q;
      if (start_s) begin
         ptmr_d = '0;
      end else if (tick_s) begin
         ptmr_d = (ptmr_q == PW'(POLL_TICKS - 1)) ? '0 : ptmr_q + PW'(1);
      end else begin
         ptmr_d = ptmr_q;
      end
   end

   // Poll sequencer: state, per-state tick count, bit index and sampling
   always_comb begin
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      bitcnt_d = bitcnt_q;
      start_s  = 1'b0;
      sample_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick_s && (trig_pend_q || (en_i && ptmr_q == PW'(POLL_TICKS - 1)))) begin
               start_s  = 1'b1;
               state_d  = S_LATCH;
               tcnt_d   = '0;
               bitcnt_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LATCH: begin
            if (tick_s && tcnt_q == TW'(LATCH_TICKS - 1)) begin
               sample_s = 1'b1;
               bitcnt_d = bitcnt_q + BW'(1);
               tcnt_d   = '0;
               state_d  = S_PHI;
            end else if (tick_s) begin
               tcnt_d = tcnt_q + TW'(1);
            end else begin
               tcnt_d = tcnt_q;
            end
         end
         S_PHI: begin
            if (tick_s && tcnt_q == TW'(HALF_TICKS - 1)) begin
               tcnt_d  = '0;
               state_d = S_PLO;
            end else if (tick_s) begin
               tcnt_d = tcnt_q + TW'(1);
            end else begin
               tcnt_d = tcnt_q;
            end
         end
         S_PLO: begin
            if (tick_s && tcnt_q == TW'(HALF_TICKS - 1)) begin
               sample_s = 1'b1;
               bitcnt_d = bitcnt_q + BW'(1);
               tcnt_d   = '0;
               state_d  = (bitcnt_q + BW'(1) < BW'(BITS)) ? S_PHI : S_DONE;
            end else if (tick_s) begin
               tcnt_d = tcnt_q + TW'(1);
            end else begin
               tcnt_d = tcnt_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Every pad shifts in parallel; bitcnt_q selects the raw bit being captured
      raw_d = raw_q;
      for (int p = 0; p < NUM_PADS; p++) begin
         for (int i = 0; i < BITS; i++) begin
            if (sample_s && bitcnt_q == BW'(i)) begin
               raw_d[p*BITS+i] = sync2_q[p];
            end else begin
               raw_d[p*BITS+i] = raw_q[p*BITS+i];
            end
         end
      end
   end

   // Sticky trigger request and result words loaded on entry to DONE
   always_comb begin
      trig_pend_d = start_s ? 1'b0 : ((trig_i && state_q == S_IDLE) ? 1'b1 : trig_pend_q);
      buttons_d   = buttons_q;
      present_d   = present_q;
      if (state_d == S_DONE) begin
         buttons_d = ~raw_d;
         for (int p = 0; p < NUM_PADS; p++) begin
            present_d[p] = (raw_d[p*BITS +: BITS] != {BITS{1'b1}});
         end
      end else begin
         buttons_d = buttons_q;
         present_d = present_q;
      end
   end

   // State, counters, synchroniser and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         ptmr_q      <= '0;
         tcnt_q      <= '0;
         bitcnt_q    <= '0;
         trig_pend_q <= 1'b0;
         sync1_q     <= {NUM_PADS{1'b1}};
         sync2_q     <= {NUM_PADS{1'b1}};
         raw_q       <= '0;
         latch_q     <= 1'b0;
         pulse_q     <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         buttons_q   <= '0;
         present_q   <= '0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         ptmr_q      <= ptmr_d;
         tcnt_q      <= tcnt_d;
         bitcnt_q    <= bitcnt_d;
         trig_pend_q <= trig_pend_d;
         sync1_q     <= pad_data_i;
         sync2_q     <= sync1_q;
         raw_q       <= raw_d;
         latch_q     <= (state_d == S_LATCH);
         pulse_q     <= (state_d == S_PHI);
         busy_q      <= (state_d != S_IDLE);
         valid_q     <= (state_d == S_DONE);
         buttons_q   <= buttons_d;
         present_q   <= present_d;
      end
   end

   assign pad_latch_o = latch_q;
   assign pad_pulse_o = pulse_q;
   assign buttons_o   = buttons_q;
   assign present_o   = present_q;
   assign valid_o     = valid_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_t03_pad_poller.sv
// Bench for t03_pad_poller: an 8-bit and a 16-bit instance driven by behavioural serial-pad
// models, with results compared against a word-level reference computed from the pad contents.
module tb_t03_pad_poller;

   localparam int DIV   = 4;
   localparam int LT    = 3;
   localparam int HT    = 2;
   localparam int PT    = 100;
   localparam int LAT8  = (LT + 2*HT*(8-1))*DIV + 1;
   localparam int LAT16 = (LT + 2*HT*(16-1))*DIV + 1;

   logic clk = 1'b0;
   logic rst;
   logic en8, trig8, en16, trig16;
   logic [1:0]  pd8, pd16;
   logic        latch8, pulse8, valid8, busy8;
   logic [15:0] btn8;
   logic [1:0]  pres8;
   logic        latch16, pulse16, valid16, busy16;
   logic [31:0] btn16;
   logic [1:0]  pres16;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   t03_pad_poller #(.NUM_PADS(2), .BITS(8), .DIV(DIV), .LATCH_TICKS(LT),
                    .HALF_TICKS(HT), .POLL_TICKS(PT)) u_dut (
      .clk(clk), .rst(rst), .en_i(en8), .trig_i(trig8), .pad_data_i(pd8),
      .pad_latch_o(latch8), .pad_pulse_o(pulse8), .buttons_o(btn8),
      .present_o(pres8), .valid_o(valid8), .busy_o(busy8));

   t03_pad_poller #(.NUM_PADS(2), .BITS(16), .DIV(DIV), .LATCH_TICKS(LT),
                    .HALF_TICKS(HT), .POLL_TICKS(PT)) u_dut16 (
      .clk(clk), .rst(rst), .en_i(en16), .trig_i(trig16), .pad_data_i(pd16),
      .pad_latch_o(latch16), .pad_pulse_o(pulse16), .buttons_o(btn16),
      .present_o(pres16), .valid_o(valid16), .busy_o(busy16));

   // Pad models: line word bit k is driven after k pulse rising edges; unplugged pads float high
   logic [15:0] line8 [2];
   logic [15:0] line16 [2];
   logic [1:0]  plug8, plug16;
   int   idx8 = 0, idx16 = 0;
   logic pp8 = 1'b0, pp16 = 1'b0;

   always @(posedge clk) begin
      pp8  <= pulse8;
      pp16 <= pulse16;
      if (latch8) idx8 <= 0; else if (pulse8 && !pp8) idx8 <= idx8 + 1;
      if (latch16) idx16 <= 0; else if (pulse16 && !pp16) idx16 <= idx16 + 1;
   end

   always_comb begin
      pd8  = 2'b11;
      pd16 = 2'b11;
      for (int p = 0; p < 2; p++) begin
         pd8[p]  = (plug8[p]  && idx8  < 16) ? line8[p][idx8]   : 1'b1;
         pd16[p] = (plug16[p] && idx16 < 16) ? line16[p][idx16] : 1'b1;
      end
   end

   // Output monitors
   int   cyc = 0, vcnt8 = 0, vcyc8 = 0, brise8 = 0, llen8 = 0, prises8 = 0, phi8 = 0;
   int   act8 = 0, both8 = 0, vcnt16 = 0, vcyc16 = 0, brise16 = 0, prises16 = 0, both16 = 0;
   logic lp8 = 1'b0, bp8 = 1'b0, mp8 = 1'b0, bp16 = 1'b0, mp16 = 1'b0;

   always @(negedge clk) begin
      cyc  <= cyc + 1;
      lp8  <= latch8;
      bp8  <= busy8;
      mp8  <= pulse8;
      bp16 <= busy16;
      mp16 <= pulse16;
      if (latch8 && !lp8) begin
         llen8 <= 1; prises8 <= 0; phi8 <= 0;
      end else begin
         if (latch8) llen8 <= llen8 + 1;
         if (pulse8 && !mp8) prises8 <= prises8 + 1;
         if (pulse8) phi8 <= phi8 + 1;
      end
      if (busy8 && !bp8) brise8 <= cyc;
      if (valid8) begin vcnt8 <= vcnt8 + 1; vcyc8 <= cyc; end
      if (latch8 || pulse8 || busy8 || valid8) act8 <= act8 + 1;
      if (latch8 && pulse8) both8 <= both8 + 1;
      if (latch16) prises16 <= 0; else if (pulse16 && !mp16) prises16 <= prises16 + 1;
      if (busy16 && !bp16) brise16 <= cyc;
      if (valid16) begin vcnt16 <= vcnt16 + 1; vcyc16 <= cyc; end
      if (latch16 && pulse16) both16 <= both16 + 1;
   end

   // Reference: pressed = inverted line bits of plugged pads; present = any 0 on a plugged line
   function automatic logic [31:0] exp_buttons(input int bits, input logic [15:0] l0,
                                               input logic [15:0] l1, input logic [1:0] plug);
      logic [31:0] r;
      r = 32'h0;
      for (int i = 0; i < bits; i++) begin
         r[i]      = plug[0] ? ~l0[i] : 1'b0;
         r[bits+i] = plug[1] ? ~l1[i] : 1'b0;
      end
      return r;
   endfunction

   function automatic logic [1:0] exp_present(input int bits, input logic [15:0] l0,
                                              input logic [15:0] l1, input logic [1:0] plug);
      logic [15:0] m;
      m = 16'((32'd1 << bits) - 32'd1);
      return {plug[1] && ((l1 & m) != m), plug[0] && ((l0 & m) != m)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid8(input int budget, output bit ok);
      int v0;
      v0 = vcnt8;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk); #1;
         if (vcnt8 != v0) ok = 1'b1;
      end
   endtask

   task automatic wait_busy8(input logic lvl, input int budget);
      for (int i = 0; i < budget && busy8 !== lvl; i++) @(negedge clk);
   endtask

   task automatic poll8(input string tag);
      bit ok;
      @(negedge clk) trig8 = 1'b1;
      @(negedge clk) trig8 = 1'b0;
      wait_valid8(300, ok);
      check({tag, "_timeout"}, 64'(ok), 64'd1);
      check({tag, "_buttons"}, 64'(btn8), 64'(exp_buttons(8, line8[0], line8[1], plug8)));
      check({tag, "_present"}, 64'(pres8), 64'(exp_present(8, line8[0], line8[1], plug8)));
      check({tag, "_latency"}, 64'(vcyc8 - brise8 + 1), 64'(LAT8));
      check({tag, "_latch_clk"}, 64'(llen8), 64'(LT*DIV));
      check({tag, "_pulses"}, 64'(prises8), 64'd7);
      check({tag, "_pulse_hi_clk"}, 64'(phi8), 64'(7*HT*DIV));
      @(negedge clk); #1;
      check({tag, "_valid_1clk"}, 64'(valid8), 64'd0);
   endtask

   task automatic poll16(input string tag);
      int  v0;
      bit  ok;
      v0 = vcnt16;
      ok = 1'b0;
      @(negedge clk) trig16 = 1'b1;
      @(negedge clk) trig16 = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk); #1;
         if (vcnt16 != v0) ok = 1'b1;
      end
      check({tag, "_timeout"}, 64'(ok), 64'd1);
      check({tag, "_buttons"}, 64'(btn16), 64'(exp_buttons(16, line16[0], line16[1], plug16)));
      check({tag, "_present"}, 64'(pres16), 64'(exp_present(16, line16[0], line16[1], plug16)));
      check({tag, "_latency"}, 64'(vcyc16 - brise16 + 1), 64'(LAT16));
      check({tag, "_pulses"}, 64'(prises16), 64'd15);
   endtask

   initial begin
      bit ok;
      int t1, n;
      rst = 1'b1; en8 = 1'b0; trig8 = 1'b0; en16 = 1'b0; trig16 = 1'b0;
      line8[0] = 16'hFFFF; line8[1] = 16'hFFFF; plug8 = 2'b11;
      line16[0] = 16'hFFFF; line16[1] = 16'hFFFF; plug16 = 2'b11;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle after reset: nothing moves
      repeat (200) @(negedge clk);
      #1;
      check("rst_buttons", 64'(btn8), 64'd0);
      check("rst_present", 64'(pres8), 64'd0);
      check("rst_strobes", 64'({latch8, pulse8, valid8, busy8}), 64'd0);
      check("idle_activity", 64'(act8), 64'd0);

      // Directed NES poll: pressed 8'h5A on pad0, 8'h81 on pad1
      line8[0] = 16'(~8'h5A); line8[1] = 16'(~8'h81); plug8 = 2'b11;
      poll8("nes");
      check("nes_word", 64'(btn8), 64'h815A);
      check("nes_present", 64'(pres8), 64'h3);

      // Pad1 unplugged, pad0 line all zero (every button pressed)
      line8[0] = 16'h0000; plug8 = 2'b01;
      poll8("unplug");
      check("unplug_word", 64'(btn8), 64'h00FF);
      check("unplug_present", 64'(pres8), 64'h1);

      // Buttons/present hold between polls
      repeat (50) @(negedge clk); #1;
      check("hold_word", 64'(btn8), 64'h00FF);

      // Random pad contents; first round has pad0 plugged with nothing pressed
      for (int k = 0; k < 6; k++) begin
         line8[0] = 16'($urandom);
         line8[1] = 16'($urandom);
         plug8    = 2'($urandom_range(0, 3));
         if (k == 0) begin line8[0] = 16'hFFFF; plug8 = 2'b11; end
         poll8("rnd");
      end

      // Auto-polling period and trig-while-busy
      en8 = 1'b1;
      wait_valid8(600, ok);
      check("auto_first", 64'(ok), 64'd1);
      t1 = vcyc8;
      wait_valid8(600, ok);
      check("auto_period", 64'(vcyc8 - t1), 64'd400);
      t1 = vcyc8;
      wait_busy8(1'b0, 50);
      wait_busy8(1'b1, 500);
      repeat (20) @(negedge clk);
      trig8 = 1'b1;
      @(negedge clk) trig8 = 1'b0;
      wait_valid8(600, ok);
      check("busy_trig_period", 64'(vcyc8 - t1), 64'd400);
      n = vcnt8;
      repeat (200) @(negedge clk);
      check("busy_trig_dropped", 64'(vcnt8), 64'(n));
      wait_busy8(1'b1, 500);
      en8 = 1'b0;
      wait_valid8(300, ok);
      check("en_off_completes", 64'(ok), 64'd1);
      n = vcnt8;
      repeat (600) @(negedge clk);
      check("en_off_stops", 64'(vcnt8), 64'(n));

      // Reset during the 4th pulse aborts the poll
      line8[0] = 16'h1234; line8[1] = 16'h00C3; plug8 = 2'b11;
      @(negedge clk) trig8 = 1'b1;
      @(negedge clk) trig8 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk); #1;
         if (prises8 == 4 && pulse8) ok = 1'b1;
      end
      check("pulse4_reached", 64'(ok), 64'd1);
      rst = 1'b1;
      #1;
      check("abort_strobes", 64'({latch8, pulse8, busy8, valid8}), 64'd0);
      check("abort_buttons", 64'(btn8), 64'd0);
      n = vcnt8;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("abort_no_valid", 64'(vcnt8), 64'(n));
      line8[0] = 16'($urandom); line8[1] = 16'($urandom);
      poll8("after_rst");

      // SNES-width instance
      line16[0] = ~16'hA5C3; line16[1] = 16'($urandom); plug16 = 2'b11;
      poll16("snes");
      check("snes_word0", 64'(btn16[15:0]), 64'hA5C3);
      for (int k = 0; k < 2; k++) begin
         line16[0] = 16'($urandom); line16[1] = 16'($urandom);
         plug16 = 2'($urandom_range(0, 3));
         poll16("snes_rnd");
      end

      check("never_both_high8", 64'(both8), 64'd0);
      check("never_both_high16", 64'(both16), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
